// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN      = 2'd1,
        RECFG    = 2'd2
    } state_e;

    localparam int DEFAULT_DIV = 20;
    localparam int MIN_DIV     = 2;
    localparam int BYTE_W      = 8;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the receive controller, the bit-level receiver and the byte consumer.
interface uart_rx_ctrl_if
    import uart_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);

    logic                     ctrl_en;
    logic                     cfg_div_wr;
    logic [DIV_W-1:0]         cfg_div;
    logic                     baud_tick;
    logic                     rx_en;
    logic                     rx_busy;
    logic                     rx_done;
    logic [BYTE_W-1:0]        rx_data;
    logic                     rx_valid;
    logic [BYTE_W-1:0]        m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic [CNT_W-1:0]         frame_err_cnt;
    logic [CNT_W-1:0]         overrun_cnt;
    logic                     cfg_pending;

    // Controller side
    modport slave (
        input  ctrl_en, cfg_div_wr, cfg_div, rx_busy, rx_done, rx_data, rx_valid, m_ready,
        output baud_tick, rx_en, m_data, m_valid, fifo_level, frame_err_cnt, overrun_cnt,
        cfg_pending
    );

    // Environment side (receiver, consumer, software)
    modport master (
        output ctrl_en, cfg_div_wr, cfg_div, rx_busy, rx_done, rx_data, rx_valid, m_ready,
        input  baud_tick, rx_en, m_data, m_valid, fifo_level, frame_err_cnt, overrun_cnt,
        cfg_pending
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small circular byte FIFO; head is read combinationally from registered storage.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [BYTE_W-1:0]      data_i,
    input  logic                   pop_i,
    output logic [BYTE_W-1:0]      data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_q, rd_q;
    logic              do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level_o = wr_q - rd_q;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick generation, safe divisor reconfiguration,
// received-byte FIFO and saturating error/overrun counters.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 8
) (
    input logic            clk,
    input logic            rst,
    uart_rx_ctrl_if.slave  bus
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ferr_q, ferr_d;
    logic [CNT_W-1:0] ovr_q, ovr_d;
    logic [DIV_W-1:0] newest_div;
    logic             running, tick;
    logic             push, pop, full, empty;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign running = (state_q != DISABLED);
    assign tick    = running && (cnt_q == div_q - DIV_W'(1));

    // A write in the same cycle as the apply decision supersedes the stored pending value
    assign newest_div = bus.cfg_div_wr ? bus.cfg_div : pend_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pend_d  = pend_q;
        cnt_d   = running ? (tick ? '0 : cnt_q + DIV_W'(1)) : '0;
        unique case (state_q)
            DISABLED: begin
                if (bus.cfg_div_wr) div_d = clamp_div(bus.cfg_div);
                if (bus.ctrl_en)    state_d = RUN;
            end
            RUN: begin
                if (!bus.ctrl_en) begin
                    if (bus.cfg_div_wr) div_d = clamp_div(bus.cfg_div);
                    state_d = DISABLED;
                end else if (bus.cfg_div_wr) begin
                    if (bus.rx_busy) begin
                        pend_d  = bus.cfg_div;
                        state_d = RECFG;
                    end else begin
                        div_d = clamp_div(bus.cfg_div);
                        cnt_d = '0;
                    end
                end
            end
            RECFG: begin
                pend_d = newest_div;
                if (!bus.ctrl_en) begin
                    div_d   = clamp_div(newest_div);
                    pend_d  = '0;
                    state_d = DISABLED;
                end else if (!bus.rx_busy) begin
                    div_d   = clamp_div(newest_div);
                    pend_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            default: state_d = DISABLED;
        endcase
    end

    always_comb begin
        ferr_d = ferr_q;
        ovr_d  = ovr_q;
        if (bus.rx_done && !bus.rx_valid)                 ferr_d = sat_inc(ferr_q);
        if (bus.rx_done && bus.rx_valid && full && !pop)  ovr_d  = sat_inc(ovr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DISABLED;
            div_q   <= RST_DIV;
            pend_q  <= '0;
            cnt_q   <= '0;
            ferr_q  <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign pop  = !empty && bus.m_ready;
    assign push = bus.rx_done && bus.rx_valid && (!full || pop);

    uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (bus.rx_data),
        .pop_i   (pop),
        .data_o  (bus.m_data),
        .full_o  (full),
        .empty_o (empty),
        .level_o (bus.fifo_level)
    );

    assign bus.m_valid       = !empty;
    assign bus.baud_tick     = tick;
    assign bus.rx_en         = running;
    assign bus.cfg_pending   = (state_q == RECFG);
    assign bus.frame_err_cnt = ferr_q;
    assign bus.overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: tick timing, FIFO ordering/overrun, deferred reconfiguration, saturation, reset.
module tb_uart_rx_ctrl;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   n;

    uart_rx_ctrl_if #(.DIV_W(16), .DEPTH(4), .CNT_W(8)) bus ();

    uart_rx_ctrl #(.DIV_W(16), .DEFAULT_DIV(20), .DEPTH(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic v);
        bus.rx_done  = 1'b1;
        bus.rx_data  = b;
        bus.rx_valid = v;
        step(1);
        bus.rx_done  = 1'b0;
        bus.rx_valid = 1'b0;
    endtask

    // Cycles advanced until baud_tick is seen (bounded)
    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            step(1);
            cyc++;
        end while (!bus.baud_tick && cyc < 200);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.ctrl_en    = 1'b0;
        bus.cfg_div_wr = 1'b0;
        bus.cfg_div    = '0;
        bus.rx_busy    = 1'b0;
        bus.rx_done    = 1'b0;
        bus.rx_data    = '0;
        bus.rx_valid   = 1'b0;
        bus.m_ready    = 1'b0;
        step(2);
        rst = 1'b0;

        chk("rst_rx_en", bus.rx_en, 0);
        chk("rst_tick", bus.baud_tick, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_level", bus.fifo_level, 0);
        chk("rst_ferr", bus.frame_err_cnt, 0);
        chk("rst_ovr", bus.overrun_cnt, 0);
        chk("rst_pending", bus.cfg_pending, 0);

        // Test 1: tick timing at default divisor
        bus.ctrl_en = 1'b1;
        wait_tick(n);
        chk("first_tick", n, 20);
        chk("run_rx_en", bus.rx_en, 1);
        wait_tick(n);
        chk("tick_period20", n, 20);

        // Test 2: fill, overrun, drain in order
        rx_frame(8'hA5, 1'b1);
        chk("latency_valid", bus.m_valid, 1);
        chk("latency_data", bus.m_data, 8'hA5);
        rx_frame(8'h3C, 1'b1);
        rx_frame(8'hFF, 1'b1);
        rx_frame(8'h00, 1'b1);
        chk("full_level", bus.fifo_level, 4);
        rx_frame(8'h11, 1'b1);
        chk("overrun1", bus.overrun_cnt, 1);
        chk("overrun_level", bus.fifo_level, 4);
        chk("head_stable", bus.m_data, 8'hA5);
        bus.m_ready = 1'b1;
        chk("out0", bus.m_data, 8'hA5);
        step(1);
        chk("out1", bus.m_data, 8'h3C);
        step(1);
        chk("out2", bus.m_data, 8'hFF);
        step(1);
        chk("out3", bus.m_data, 8'h00);
        chk("out3_valid", bus.m_valid, 1);
        step(1);
        chk("drained_valid", bus.m_valid, 0);
        chk("drained_level", bus.fifo_level, 0);
        bus.m_ready = 1'b0;

        // Test 3: push into full FIFO together with a pop
        rx_frame(8'h01, 1'b1);
        rx_frame(8'h02, 1'b1);
        rx_frame(8'h03, 1'b1);
        rx_frame(8'h04, 1'b1);
        chk("refill_level", bus.fifo_level, 4);
        bus.m_ready = 1'b1;
        chk("pp_head", bus.m_data, 8'h01);
        rx_frame(8'h77, 1'b1);
        bus.m_ready = 1'b0;
        chk("pp_level", bus.fifo_level, 4);
        chk("pp_no_overrun", bus.overrun_cnt, 1);
        bus.m_ready = 1'b1;
        chk("pp_out0", bus.m_data, 8'h02);
        step(1);
        chk("pp_out1", bus.m_data, 8'h03);
        step(1);
        chk("pp_out2", bus.m_data, 8'h04);
        step(1);
        chk("pp_last", bus.m_data, 8'h77);
        step(1);
        chk("pp_empty", bus.m_valid, 0);
        bus.m_ready = 1'b0;

        // Test 4: deferred reconfiguration while busy, last write wins
        bus.rx_busy    = 1'b1;
        bus.cfg_div    = 16'd10;
        bus.cfg_div_wr = 1'b1;
        step(1);
        bus.cfg_div_wr = 1'b0;
        chk("pending_set", bus.cfg_pending, 1);
        chk("recfg_rx_en", bus.rx_en, 1);
        wait_tick(n);
        wait_tick(n);
        chk("recfg_old_period", n, 20);
        bus.cfg_div    = 16'd8;
        bus.cfg_div_wr = 1'b1;
        step(1);
        bus.cfg_div_wr = 1'b0;
        chk("pending_still", bus.cfg_pending, 1);
        bus.rx_busy = 1'b0;
        step(1);
        chk("pending_clr", bus.cfg_pending, 0);
        wait_tick(n);
        chk("recfg_first8", n, 7);
        wait_tick(n);
        chk("recfg_period8", n, 8);

        // Test 5: clamp of divisor 1, frame-error saturation
        bus.cfg_div    = 16'd1;
        bus.cfg_div_wr = 1'b1;
        step(1);
        bus.cfg_div_wr = 1'b0;
        wait_tick(n);
        chk("clamp_first", n, 1);
        wait_tick(n);
        chk("clamp_period", n, 2);
        for (int i = 0; i < 300; i++) begin
            rx_frame(8'(i), 1'b0);
            if (i == 9) chk("ferr10", bus.frame_err_cnt, 10);
        end
        chk("ferr_sat", bus.frame_err_cnt, 255);
        chk("ferr_no_push", bus.fifo_level, 0);
        chk("ferr_ovr_kept", bus.overrun_cnt, 1);

        // Test 6: disable keeps FIFO; reset during RECFG
        rx_frame(8'h5A, 1'b1);
        rx_frame(8'h6B, 1'b1);
        bus.ctrl_en = 1'b0;
        step(1);
        chk("dis_rx_en", bus.rx_en, 0);
        chk("dis_tick", bus.baud_tick, 0);
        chk("dis_level", bus.fifo_level, 2);
        chk("dis_head", bus.m_data, 8'h5A);
        bus.ctrl_en = 1'b1;
        step(1);
        bus.rx_busy    = 1'b1;
        bus.cfg_div    = 16'd50;
        bus.cfg_div_wr = 1'b1;
        step(1);
        bus.cfg_div_wr = 1'b0;
        chk("r6_pending", bus.cfg_pending, 1);
        rst = 1'b1;
        step(1);
        chk("r6_level", bus.fifo_level, 0);
        chk("r6_m_valid", bus.m_valid, 0);
        chk("r6_pending_clr", bus.cfg_pending, 0);
        chk("r6_rx_en", bus.rx_en, 0);
        chk("r6_ferr", bus.frame_err_cnt, 0);
        chk("r6_ovr", bus.overrun_cnt, 0);
        rst = 1'b0;
        bus.rx_busy = 1'b0;
        wait_tick(n);
        chk("r6_div_default", n, 20);
        wait_tick(n);
        chk("r6_period", n, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
